// File: rtl/fifo_rd_port_if.sv
// fifo_rd_port_if: bundles the FIFO-side read interface and the downstream
// valid/ready interface of fifo_rd_port.
//   fifo_empty_i  FIFO empty flag
//   fifo_data_i   FIFO read data (valid one cycle after an accepted rd_en)
//   fifo_rd_en_o  FIFO read enable
//   flush_i       drop all buffered and in-flight words
//   data_o        head word presented downstream
//   valid_o       data_o is valid
//   ready_i       downstream accepts data_o this cycle
// Modports: slave = the read-port block, master = its environment.
interface fifo_rd_port_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty_i;
  logic [DATA_W-1:0] fifo_data_i;
  logic              fifo_rd_en_o;
  logic              flush_i;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              ready_i;

  modport slave (
    input  fifo_empty_i, fifo_data_i, flush_i, ready_i,
    output fifo_rd_en_o, data_o, valid_o
  );

  modport master (
    output fifo_empty_i, fifo_data_i, flush_i, ready_i,
    input  fifo_rd_en_o, data_o, valid_o
  );
endinterface

// File: rtl/fifo_rd_port.sv
// fifo_rd_port: drain-side controller for a circular FIFO with a 1-cycle
// registered read latency. Issues read enables only while the skid buffer
// can absorb every word already requested, captures returning words into a
// 2**BUF_DEPTH_W entry circular buffer and presents the head word on a
// valid/ready handshake (1 word/cycle sustained).
// Ports:
//   clk_i        clock, all state on rising edge
//   rst_i        synchronous active-high reset
//   bus          fifo_rd_port_if.slave (FIFO read side + downstream side)
//   stall_cnt_o  saturating count of valid & !ready cycles
//                (only with FIFO_RD_STALL_CNT_EN defined)
// Optional feature macro: FIFO_RD_STALL_CNT_EN
module fifo_rd_port #(
  parameter int DATA_W      = 8,
  parameter int BUF_DEPTH_W = 1,
  parameter int CNT_W       = 16,
  parameter int ID          = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  fifo_rd_port_if.slave     bus
`ifdef FIFO_RD_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

  localparam int DEPTH = 1 << BUF_DEPTH_W;
  localparam logic [BUF_DEPTH_W+1:0] OCC_LIMIT = (BUF_DEPTH_W+2)'(DEPTH);

  if (BUF_DEPTH_W < 1 || BUF_DEPTH_W > 4 || CNT_W < 1 || ID < 0) begin : g_param_chk
    $error("fifo_rd_port: illegal parameter value");
  end

  typedef logic [BUF_DEPTH_W-1:0] ptr_t;

  logic [BUF_DEPTH_W:0]            count_q, count_d;
  ptr_t                            wr_ptr_q, wr_ptr_d;
  ptr_t                            rd_ptr_q, rd_ptr_d;
  logic                            inflight_q, inflight_d;
  logic [DEPTH-1:0][DATA_W-1:0]    mem_q, mem_d;

  logic                 valid;
  logic                 pop;
  logic                 capture;
  logic                 rd_en;
  logic [BUF_DEPTH_W+1:0] occ;

  assign valid   = (count_q != '0);
  assign pop     = valid & bus.ready_i;
  assign capture = inflight_q & ~bus.flush_i;

  // Occupancy after this edge if nothing new were requested: words held plus
  // the word already on its way back, minus the one leaving. Never negative
  // because pop implies count_q >= 1. Keeping it below DEPTH guarantees a
  // slot for the word a read issued now will return next cycle.
  assign occ   = {1'b0, count_q} + (BUF_DEPTH_W+2)'(inflight_q)
               - (BUF_DEPTH_W+2)'(pop);
  assign rd_en = ~bus.fifo_empty_i & ~bus.flush_i & ~rst_i & (occ < OCC_LIMIT);

  always_comb begin
    count_d    = count_q + (BUF_DEPTH_W+1)'(capture) - (BUF_DEPTH_W+1)'(pop);
    wr_ptr_d   = wr_ptr_q + ptr_t'(capture);
    rd_ptr_d   = rd_ptr_q + ptr_t'(pop);
    inflight_d = rd_en;
    mem_d      = mem_q;
    if (capture) mem_d[wr_ptr_q] = bus.fifo_data_i;
    // Flush discards buffer state and the returning word; storage contents
    // are left alone since the pointers no longer reference them.
    if (bus.flush_i) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      mem_q      <= '0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      mem_q      <= mem_d;
    end
  end

  assign bus.fifo_rd_en_o = rd_en;
  assign bus.valid_o      = valid;
  assign bus.data_o       = mem_q[rd_ptr_q];

`ifdef FIFO_RD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating; only reset clears it so flushes keep the history.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid & ~bus.ready_i & (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_port.sv
// Directed bench for fifo_rd_port: a behavioural FIFO with 1-cycle read
// latency feeds the DUT; cycle tables cover burst drain, backpressure and
// flush; hand-written sequences cover idle reset, random ready, reset
// mid-operation and (when enabled) the stall counter.
module tb_fifo_rd_port;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_rd_port_if #(.DATA_W(8)) bif ();

`ifdef FIFO_RD_STALL_CNT_EN
  logic [3:0] stall_cnt;
  fifo_rd_port #(.DATA_W(8), .BUF_DEPTH_W(1), .CNT_W(4), .ID(0)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bif.slave), .stall_cnt_o(stall_cnt));
`else
  fifo_rd_port #(.DATA_W(8), .BUF_DEPTH_W(1), .CNT_W(16), .ID(0)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bif.slave));
`endif

  typedef struct packed {
    logic       ready;
    logic       flush;
    logic       rd;
    logic       v;
    logic [7:0] d;
    logic       chkd;
  } vec_t;

  vec_t       vec [30];
  logic [7:0] fq  [$];
  logic [7:0] got [$];
  int n_chk = 0;
  int n_fail = 0;
  int rd_empty_viol = 0;
  int cnt_viol = 0;

  always @(negedge clk)
    if (rst === 1'b0 && dut.count_q > 2) cnt_viol++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, then update the FIFO model
  // (data registered one cycle after an accepted rd_en).
  task automatic tick();
    logic rd;
    if (bif.fifo_rd_en_o && bif.fifo_empty_i) rd_empty_viol++;
    rd = bif.fifo_rd_en_o;
    if (bif.valid_o && bif.ready_i) got.push_back(bif.data_o);
    @(posedge clk);
    #1;
    if (rd && fq.size() > 0) bif.fifo_data_i = fq.pop_front();
    bif.fifo_empty_i = (fq.size() == 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bif.flush_i = 1'b0;
    bif.ready_i = 1'b0;
    fq.delete();
    bif.fifo_empty_i = 1'b1;
    repeat (2) begin #1; tick(); end
    rst = 1'b0;
  endtask

  task automatic preload(input int base, input int n);
    for (int k = 0; k < n; k++) fq.push_back(8'(base + k));
    bif.fifo_empty_i = (fq.size() == 0);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bif.ready_i = vec[i].ready;
      bif.flush_i = vec[i].flush;
      #1;
      check($sformatf("vec%0d.rd_en", i), 32'(bif.fifo_rd_en_o), 32'(vec[i].rd));
      check($sformatf("vec%0d.valid", i), 32'(bif.valid_o), 32'(vec[i].v));
      if (vec[i].chkd)
        check($sformatf("vec%0d.data", i), 32'(bif.data_o), 32'(vec[i].d));
      tick();
    end
    bif.flush_i = 1'b0;
  endtask

  initial begin
    int errs;
    // ready, flush, rd_en, valid, data, check-data
    // Burst 0x11,0x22,0x33 with ready high.
    vec[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
    vec[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
    vec[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1};
    vec[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1};
    vec[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1};
    vec[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    // 8 words 0xA0..0xA7, ready low then high: exactly 2 reads then stall.
    vec[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
    vec[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
    vec[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b1};
    vec[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b1};
    vec[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b1};
    vec[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hA0, 1'b1};
    vec[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b1};
    vec[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hA2, 1'b1};
    vec[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hA3, 1'b1};
    vec[15] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hA4, 1'b1};
    vec[16] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1};
    vec[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA6, 1'b1};
    vec[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA7, 1'b1};
    vec[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    // 5 words 0xB0..0xB4, flush while 0xB2 is returning.
    vec[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
    vec[21] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
    vec[22] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hB0, 1'b1};
    vec[23] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hB0, 1'b1};
    vec[24] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hB1, 1'b1};
    vec[25] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vec[26] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vec[27] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hB3, 1'b1};
    vec[28] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hB4, 1'b1};
    vec[29] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};

    bif.fifo_data_i = 8'h00;
    do_reset();

    // Idle after reset with an empty FIFO.
    bif.ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      check($sformatf("idle%0d.valid", c), 32'(bif.valid_o), 0);
      check($sformatf("idle%0d.rd_en", c), 32'(bif.fifo_rd_en_o), 0);
      check($sformatf("idle%0d.data", c), 32'(bif.data_o), 0);
      tick();
    end

    do_reset(); fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33);
    bif.fifo_empty_i = 1'b0;
    run_rows(0, 5);
    do_reset(); preload(8'hA0, 8); got.delete();
    run_rows(6, 19);
    errs = 0;
    for (int k = 0; k < 8; k++) if (k >= got.size() || got[k] !== 8'(8'hA0 + k)) errs++;
    check("bp.order", 32'(errs), 0);
    do_reset(); preload(8'hB0, 5);
    run_rows(20, 29);

    // Random ready, 200 words in order.
    do_reset(); preload(0, 200); got.delete();
    for (int c = 0; c < 3000 && got.size() < 200; c++) begin
      bif.ready_i = 1'($urandom_range(0, 1));
      #1;
      tick();
    end
    check("rand.count", got.size(), 200);
    errs = 0;
    for (int k = 0; k < got.size(); k++) if (got[k] !== 8'(k)) errs++;
    check("rand.order", 32'(errs), 0);

    // Reset mid-operation: rd_en gated by reset, storage cleared, the word
    // returning after release is ignored.
    do_reset(); preload(8'hC0, 4); bif.ready_i = 1'b0;
    #1; tick(); #1; tick();
    bif.ready_i = 1'b1; rst = 1'b1;
    #1;
    check("midrst.rd_en", 32'(bif.fifo_rd_en_o), 0);
    tick();
    rst = 1'b0;
    #1;
    check("midrst.valid", 32'(bif.valid_o), 0);
    check("midrst.data", 32'(bif.data_o), 0);
    tick(); #1;
    check("midrst.ignored", 32'(bif.valid_o), 0);

`ifdef FIFO_RD_STALL_CNT_EN
    do_reset(); preload(8'h55, 1); bif.ready_i = 1'b0;
    #1;
    check("stall.reset", 32'(stall_cnt), 0);
    repeat (22) begin #1; tick(); end
    check("stall.sat", 32'(stall_cnt), 15);
    rst = 1'b1; #1; tick(); rst = 1'b0; #1;
    check("stall.clear", 32'(stall_cnt), 0);
`endif

    check("rd_while_empty", 32'(rd_empty_viol), 0);
    check("count_le_depth", 32'(cnt_viol), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_port.md
Name: fifo_rd_port

Overview:
- Drain-side controller for a circular FIFO: issues read enables, absorbs the FIFO's 1-cycle registered read latency, presents data downstream on a valid/ready handshake.
- Sits between a router input-buffer FIFO and the crossbar/output stage.
- Holds data in a small internal skid buffer so back-to-back pops sustain 1 word/cycle with no underflow reads.

Parameters:
- DATA_W, 8, data word width; must match the attached FIFO.
- BUF_DEPTH_W, 1, skid buffer depth is 2**BUF_DEPTH_W entries; legal range 1..4.
- CNT_W, 16, stall counter width; used only with FIFO_RD_STALL_CNT_EN.
- ID, 0, instance identifier, debug only.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_data_i  in  DATA_W  FIFO read data; valid 1 cycle after an accepted rd_en.
- fifo_rd_en_o  out  1  FIFO read enable.
- flush_i  in  1  drop all buffered and in-flight words.
- data_o  out  DATA_W  head word of the skid buffer.
- valid_o  out  1  data_o is valid.
- ready_i  in  1  downstream accepts data_o this cycle.
- stall_cnt_o  out  CNT_W  present only with FIFO_RD_STALL_CNT_EN.

Behaviour:
- Reset: count=0, inflight=0, wr/rd pointers=0, storage=0. Outputs: valid_o=0, data_o=0, fifo_rd_en_o=0, stall_cnt_o=0.
- State:
  - count: entries held, width BUF_DEPTH_W+1.
  - inflight: 1-bit register, equals previous-cycle fifo_rd_en_o.
  - Internal circular buffer with head/tail pointers that wrap modulo 2**BUF_DEPTH_W.
- Signals:
  - pop = valid_o & ready_i.
  - valid_o = (count != 0).
  - data_o = buffer[head], driven from registers with no combinational path from fifo_data_i.
- Read issue (combinational): fifo_rd_en_o = !fifo_empty_i & !flush_i & !rst_i & (count + inflight - pop < 2**BUF_DEPTH_W).
- Capture:
  - When inflight=1 and flush_i=0, write fifo_data_i at tail, then advance tail.
  - Each edge: count <= count + capture - pop.
- Latency: FIFO word to valid_o = 2 cycles after rd_en (1 FIFO read cycle, 1 capture cycle).
- Throughput: with BUF_DEPTH_W>=1 and ready_i held high, 1 word/cycle sustained.
- Ordering: strict FIFO order; no word duplicated or dropped except by flush_i.
- Simultaneous capture and pop on the same edge: count unchanged, both pointers advance. This is legal when count == depth.
- Overflow of the skid buffer is impossible by construction; the verifier asserts count <= 2**BUF_DEPTH_W.
- Flush:
  - flush_i=1 in a cycle: on that edge count<=0, pointers<=0, inflight<=0, and any word returning that cycle is discarded.
  - fifo_rd_en_o is forced 0 during flush.
  - valid_o may be high in the flush cycle; a pop that cycle is honoured downstream, but buffer state still clears.
- Reset mid-operation: same as flush, plus storage is cleared. A FIFO word returning in the cycle after reset release is ignored because inflight=0.
- fifo_rd_en_o never asserts while fifo_empty_i=1, so the FIFO underflow flag must never be raised by this block.

Optional Feature:
- Macro: FIFO_RD_STALL_CNT_EN.
- Defined:
  - stall_cnt_o increments by 1 on every cycle with valid_o=1 & ready_i=0.
  - It saturates at 2**CNT_W-1.
  - It clears on rst_i only; flush does not clear it.
- Undefined: stall_cnt_o port and counter are absent and no counter logic is synthesized.

Test Plan:
- Reset release, fifo_empty_i=1 for 10 cycles -> valid_o=0, fifo_rd_en_o=0 throughout, data_o=0.
- FIFO preloaded 0x11,0x22,0x33, ready_i=1 -> rd_en high 3 consecutive cycles; valid_o high for 3 consecutive cycles starting 2 cycles after the first rd_en; data_o 0x11,0x22,0x33.
- ready_i=0 with 8 words available, BUF_DEPTH_W=1 -> exactly 2 rd_en pulses, count=2, valid_o=1 with data_o=first word; after ready_i=1, all 8 words emerge in order, 1/cycle.
- Random ready_i (50%), 200 words 0x00..0xC7 -> output sequence exact, no rd_en while empty, count <= 2 at all times.
- flush_i pulsed the cycle after a rd_en with count=2 -> next cycle valid_o=0, count=0, returned word discarded; the next FIFO word appears as the first output.
- FIFO_RD_STALL_CNT_EN defined, CNT_W=4, 20 stall cycles -> stall_cnt_o=15 (saturated); rst_i -> 0.
